// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and helpers for the MEM-stage load/store unit.
// Contents: LSU FSM state enum, word/register-address widths, MEM/WB payload
// struct, and a word-alignment helper.
package mips_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        IDLE,
        WAIT
    } lsu_state_t;

    // MEM/WB pipeline-register payload
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [WORD_W-1:0]     alu_result;
        logic [WORD_W-1:0]     read_data;
        logic [REG_ADDR_W-1:0] write_reg;
    } mem_wb_t;

    function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
        return (addr & WORD_W'(3)) == '0;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack interface between the LSU (master) and memory (slave).
// Signals: MemReq, MemWe, MemAddr, MemWdata (master->slave);
//          MemAck, MemRdata (slave->master).
interface mem_stage_lsu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWdata;
    logic              MemAck;
    logic [31:0]       MemRdata;

    modport master (
        output MemReq, MemWe, MemAddr, MemWdata,
        input  MemAck, MemRdata
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWdata,
        output MemAck, MemRdata
    );
endinterface

// File: rtl/lsu_timeout_counter.sv
// WAIT-state cycle counter for the LSU access timeout.
// Ports: clk, rst_n, i_clear (sync clear), i_enable (count one cycle),
//        o_hit_c (combinational: count has reached TIMEOUT-1; never with TIMEOUT=0).
module lsu_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturating up-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_hit_c = (TIMEOUT != 0) && (r_cnt == HIT_VAL);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory accesses over a req/ack
// handshake, stalls upstream while an access is outstanding, and produces the
// registered MEM/WB payload. Non-memory instructions pass with 1-cycle latency.
// Ports: clk, rst_n; EX/MEM inputs (RegWriteIn, MemtoRegIn, MemWriteIn,
//        ALUResultIn, WriteRegIn, WriteDataIn); Stall (combinational);
//        mem (memory interface, master); MEM/WB outputs (RegWriteOut,
//        MemtoRegOut, ALUResultOut, ReadDataOut, WriteRegOut); MisalignOut and
//        TimeoutOut abort pulses.
module mem_stage_lsu
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteIn,
    input  logic                  MemtoRegIn,
    input  logic                  MemWriteIn,
    input  logic [WORD_W-1:0]     ALUResultIn,
    input  logic [REG_ADDR_W-1:0] WriteRegIn,
    input  logic [WORD_W-1:0]     WriteDataIn,
    output logic                  Stall,
    mem_stage_lsu_if.master       mem,
    output logic                  RegWriteOut,
    output logic                  MemtoRegOut,
    output logic [WORD_W-1:0]     ALUResultOut,
    output logic [WORD_W-1:0]     ReadDataOut,
    output logic [REG_ADDR_W-1:0] WriteRegOut,
    output logic                  MisalignOut,
    output logic                  TimeoutOut
);

    lsu_state_t        r_state,   w_state_nxt;
    logic              r_req,     w_req_nxt;
    logic              r_we,      w_we_nxt;
    logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
    logic [WORD_W-1:0] r_wdata,   w_wdata_nxt;
    mem_wb_t           r_memwb,   w_memwb_nxt;
    logic              r_misalign, w_misalign_nxt;
    logic              r_timeout,  w_timeout_nxt;

    logic    w_memop;
    logic    w_cnt_clear;
    logic    w_cnt_en;
    logic    w_hit_c;
    mem_wb_t w_pass;

    assign w_memop = MemtoRegIn | MemWriteIn;

    // Pass-through payload; read data is filled in only for completed loads
    assign w_pass = '{reg_write:  RegWriteIn,
                      mem_to_reg: MemtoRegIn,
                      alu_result: ALUResultIn,
                      read_data:  '0,
                      write_reg:  WriteRegIn};

    lsu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_hit_c  (w_hit_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_memwb    <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_memwb    <= w_memwb_nxt;
            r_misalign <= w_misalign_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state, next-output and stall; MEM/WB defaults to a bubble
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_memwb_nxt    = '0;
        w_misalign_nxt = 1'b0;
        w_timeout_nxt  = 1'b0;
        w_cnt_clear    = 1'b0;
        w_cnt_en       = 1'b0;
        Stall          = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_clear = 1'b1;
                if (!w_memop) begin
                    w_memwb_nxt = w_pass;
                end else if (!is_word_aligned(ALUResultIn)) begin
                    w_misalign_nxt = 1'b1;
                end else begin
                    Stall       = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = MemWriteIn;
                    w_addr_nxt  = ADDR_W'(ALUResultIn);
                    w_wdata_nxt = WriteDataIn;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Ack beats a same-cycle timeout
                if (mem.MemAck) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                    w_memwb_nxt = w_pass;
                    if (MemtoRegIn && !MemWriteIn) begin
                        w_memwb_nxt.read_data = mem.MemRdata;
                    end
                end else if (w_hit_c) begin
                    w_req_nxt     = 1'b0;
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    Stall    = 1'b1;
                    w_cnt_en = 1'b1;
                end
            end
        endcase
    end

    assign mem.MemReq   = r_req;
    assign mem.MemWe    = r_we;
    assign mem.MemAddr  = r_addr;
    assign mem.MemWdata = r_wdata;

    assign RegWriteOut  = r_memwb.reg_write;
    assign MemtoRegOut  = r_memwb.mem_to_reg;
    assign ALUResultOut = r_memwb.alu_result;
    assign ReadDataOut  = r_memwb.read_data;
    assign WriteRegOut  = r_memwb.write_reg;
    assign MisalignOut  = r_misalign;
    assign TimeoutOut   = r_timeout;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized
// instruction stream, checked against a per-instruction transaction model.
module tb_mem_stage_lsu;
    import mips_pkg::*;

    localparam int unsigned TIMEOUT = 4;
    localparam int          BUDGET  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteIn, MemtoRegIn, MemWriteIn;
    logic [31:0] ALUResultIn, WriteDataIn;
    logic [4:0]  WriteRegIn;
    logic        Stall;
    logic        RegWriteOut, MemtoRegOut, MisalignOut, TimeoutOut;
    logic [31:0] ALUResultOut, ReadDataOut;
    logic [4:0]  WriteRegOut;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_lsu_if #(.ADDR_W(32)) mem_if ();

    mem_stage_lsu #(
        .ADDR_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RegWriteIn   (RegWriteIn),
        .MemtoRegIn   (MemtoRegIn),
        .MemWriteIn   (MemWriteIn),
        .ALUResultIn  (ALUResultIn),
        .WriteRegIn   (WriteRegIn),
        .WriteDataIn  (WriteDataIn),
        .Stall        (Stall),
        .mem          (mem_if),
        .RegWriteOut  (RegWriteOut),
        .MemtoRegOut  (MemtoRegOut),
        .ALUResultOut (ALUResultOut),
        .ReadDataOut  (ReadDataOut),
        .WriteRegOut  (WriteRegOut),
        .MisalignOut  (MisalignOut),
        .TimeoutOut   (TimeoutOut)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one instruction and act as memory; ack_k = WAIT cycle carrying the ack (0 = never)
    task automatic run_instr(input logic rw, input logic mtr, input logic mw,
                             input logic [31:0] alu, input logic [31:0] wdata,
                             input logic [4:0] wreg, input int ack_k,
                             input logic [31:0] rdata);
        int          stalls = 0;
        int          reqs   = 0;
        int          cycles = 0;
        bit          done   = 0;
        bit          memop, aligned, bubble;
        int          e_req, e_stall, e_cyc;
        logic        e_rw, e_mtr, e_mis, e_to;
        logic [31:0] e_rd;
        logic [1:0]  lsb;

        // Transaction-level expectation
        memop   = mtr | mw;
        lsb     = alu[1:0];
        aligned = (lsb == 2'b00);
        e_rw = rw; e_mtr = mtr; e_mis = 0; e_to = 0; e_rd = 32'h0; bubble = 0;
        if (!memop) begin
            e_req = 0; e_stall = 0; e_cyc = 1;
        end else if (!aligned) begin
            e_req = 0; e_stall = 0; e_cyc = 1; bubble = 1; e_mis = 1;
        end else if (ack_k >= 1 && ack_k <= int'(TIMEOUT)) begin
            e_req = ack_k; e_stall = ack_k; e_cyc = ack_k + 1;
            e_rd  = mw ? 32'h0 : rdata;
        end else begin
            e_req = int'(TIMEOUT); e_stall = int'(TIMEOUT); e_cyc = int'(TIMEOUT) + 1;
            bubble = 1; e_to = 1;
        end
        if (bubble) begin
            e_rw = 0; e_mtr = 0;
        end

        RegWriteIn  = rw;
        MemtoRegIn  = mtr;
        MemWriteIn  = mw;
        ALUResultIn = alu;
        WriteDataIn = wdata;
        WriteRegIn  = wreg;

        while (!done) begin
            if (cycles >= BUDGET) begin
                n_checks++;
                n_fail++;
                $display("FAIL budget cycles=%0d limit=%0d", cycles, BUDGET);
                break;
            end
            if (mem_if.MemReq) begin
                reqs++;
                check_eq("req_addr",  mem_if.MemAddr,  alu);
                check_eq("req_we",    32'(mem_if.MemWe), 32'(mw));
                check_eq("req_wdata", mem_if.MemWdata, wdata);
                mem_if.MemAck   = (ack_k != 0) && (reqs == ack_k);
                mem_if.MemRdata = mem_if.MemAck ? rdata : $urandom;
            end else begin
                // Stray acks while idle must be ignored
                mem_if.MemAck   = 1'($urandom_range(0, 1));
                mem_if.MemRdata = $urandom;
            end
            #1;
            if (Stall) stalls++;
            done = !Stall;
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        mem_if.MemAck = 1'b0;

        check_eq("cycles",   32'(cycles), 32'(e_cyc));
        check_eq("stalls",   32'(stalls), 32'(e_stall));
        check_eq("reqs",     32'(reqs),   32'(e_req));
        check_eq("req_drop", 32'(mem_if.MemReq), 32'h0);
        check_eq("regwrite", 32'(RegWriteOut), 32'(e_rw));
        check_eq("memtoreg", 32'(MemtoRegOut), 32'(e_mtr));
        check_eq("misalign", 32'(MisalignOut), 32'(e_mis));
        check_eq("timeout",  32'(TimeoutOut),  32'(e_to));
        if (!bubble) begin
            check_eq("alu_out",  ALUResultOut, alu);
            check_eq("wreg_out", 32'(WriteRegOut), 32'(wreg));
            check_eq("rdata",    ReadDataOut, e_rd);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        RegWriteIn      = 1'b0;
        MemtoRegIn      = 1'b0;
        MemWriteIn      = 1'b0;
        ALUResultIn     = 32'h0;
        WriteDataIn     = 32'h0;
        WriteRegIn      = 5'h0;
        mem_if.MemAck   = 1'b0;
        mem_if.MemRdata = 32'h0;
        repeat (3) @(negedge clk);

        check_eq("rst_req",      32'(mem_if.MemReq), 32'h0);
        check_eq("rst_regwrite", 32'(RegWriteOut), 32'h0);
        check_eq("rst_alu",      ALUResultOut, 32'h0);
        check_eq("rst_rdata",    ReadDataOut, 32'h0);
        check_eq("rst_flags",    32'({MisalignOut, TimeoutOut, MemtoRegOut}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0, 5'd9, 0, 32'h0);
        run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd3, 3, 32'hDEAD_BEEF);
        run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5'd0, 1, 32'hCAFE_F00D);
        run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 5'd7, 1, 32'h0);
        run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd4, 0, 32'h0);
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0, 5'd12, 0, 32'h0);
        run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 5'd5, int'(TIMEOUT), 32'h5555_AAAA);
        run_instr(1'b1, 1'b1, 1'b1, 32'h0000_0048, 32'hA5A5_A5A5, 5'd6, 2, 32'h1111_2222);

        // Randomized stream
        for (int i = 0; i < 80; i++) begin
            logic        rw, mtr, mw;
            logic [31:0] alu;
            int          kind;
            kind = int'($urandom_range(0, 9));
            rw   = 1'($urandom_range(0, 1));
            if (kind < 3) begin
                mtr = 1'b0; mw = 1'b0;
            end else begin
                mtr = 1'($urandom_range(0, 1));
                mw  = ~mtr | 1'($urandom_range(0, 1));
            end
            alu = $urandom;
            if ($urandom_range(0, 4) != 0) alu = alu & 32'hFFFF_FFFC;
            else if ((alu & 32'h3) == 32'h0) alu = alu | 32'h1;
            run_instr(rw, mtr, mw, alu, $urandom, 5'($urandom_range(0, 31)),
                      int'($urandom_range(0, TIMEOUT + 1)), $urandom);
        end

        // Reset during the 2nd WAIT cycle
        RegWriteIn  = 1'b1;
        MemtoRegIn  = 1'b1;
        MemWriteIn  = 1'b0;
        ALUResultIn = 32'h0000_0080;
        WriteRegIn  = 5'd2;
        @(posedge clk);
        @(negedge clk);
        check_eq("mr_req_w1", 32'(mem_if.MemReq), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check_eq("mr_req_w2", 32'(mem_if.MemReq), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_req_async", 32'(mem_if.MemReq), 32'h0);
        RegWriteIn  = 1'b0;
        MemtoRegIn  = 1'b0;
        ALUResultIn = 32'h0;
        WriteRegIn  = 5'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n           = 1'b1;
        mem_if.MemAck   = 1'b1;
        mem_if.MemRdata = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        mem_if.MemAck = 1'b0;
        check_eq("mr_req_after", 32'(mem_if.MemReq), 32'h0);
        check_eq("mr_rdata",     ReadDataOut, 32'h0);
        check_eq("mr_ctrl",      32'({RegWriteOut, MemtoRegOut, MisalignOut, TimeoutOut}), 32'h0);
        check_eq("mr_alu",       ALUResultOut, 32'h0);
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd17, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
